// File: rtl/edge_event_arbiter.sv
// Per-channel edge counting with round-robin reporting over one valid/ready event port.
// Define EDGE_ARB_BOTH_EDGES_EN to count falling as well as rising transitions.
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] ch_en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic [N_CH-1:0] overflow,
  input  logic [N_CH-1:0] ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int unsigned      NCH_U   = N_CH;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state, state_nxt;
  logic [N_CH-1:0]   prev;
  logic [CNT_W-1:0]  cnt [N_CH];
  logic [N_CH-1:0]   edge_v;
  logic [N_CH-1:0]   take;
  logic [N_CH-1:0]   pend;
  logic [N_CH-1:0]   ovf_set;
  logic [CH_W-1:0]   last;
  logic [CH_W-1:0]   sel_ch;
  logic              sel_found;
  int unsigned       rr_idx;

  always_comb begin
`ifdef EDGE_ARB_BOTH_EDGES_EN
    edge_v = (in ^ prev) & ch_en;
`else
    edge_v = in & ~prev & ch_en;
`endif
  end

  always_comb begin
    take    = '0;
    pend    = '0;
    ovf_set = '0;
    for (int unsigned i = 0; i < NCH_U; i++) begin
      take[i]    = evt_valid & evt_ready & (evt_ch == CH_W'(i));
      pend[i]    = ch_en[i] & (cnt[i] != '0);
      ovf_set[i] = edge_v[i] & ~take[i] & (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      overflow <= '0;
      for (int unsigned i = 0; i < NCH_U; i++) cnt[i] <= '0;
    end else begin
      prev     <= in;
      overflow <= (overflow & ~ovf_clr) | ovf_set;
      for (int unsigned i = 0; i < NCH_U; i++) begin
        if (!ch_en[i])                         cnt[i] <= '0;
        else if (edge_v[i] && take[i])         cnt[i] <= cnt[i];
        else if (edge_v[i] && cnt[i] == CNT_MAX) cnt[i] <= CNT_MAX;
        else if (edge_v[i])                    cnt[i] <= cnt[i] + CNT_W'(1);
        else if (take[i] && cnt[i] != '0)      cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  // Round-robin search starts just after the last granted channel, wrapping at N_CH.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    rr_idx    = 0;
    for (int unsigned off = 1; off <= NCH_U; off++) begin
      rr_idx = 32'(last) + off;
      if (rr_idx >= NCH_U) rr_idx = rr_idx - NCH_U;
      if (!sel_found && pend[CH_W'(rr_idx)]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      evt_ch <= '0;
      last   <= CH_W'(N_CH - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_found) evt_ch <= sel_ch;
      if (state == OFFER && evt_ready) last <= evt_ch;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = OFFER;
      OFFER:   if (evt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state == OFFER);
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Samples N_CH asynchronous-free (already synchronous) level inputs and detects a rising edge per channel.
- Counts pending edge events per channel in saturating counters.
- Shares one event-reporting channel (valid/ready) between all channels with round-robin arbitration.
- Sits between per-line edge detection and a single downstream event consumer (interrupt or status logic).

Parameters:
- N_CH, 4, number of input channels (2..16).
- CNT_W, 4, width of each per-channel pending counter; saturates at 2^CNT_W-1.
- CH_W, derived localparam = $clog2(N_CH), channel index width (not overridable).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  N_CH  synchronous level inputs, one per channel.
- ch_en  in  N_CH  channel enable; 0 masks edges and clears the channel's pending count.
- evt_valid  out  1  event offered to the consumer.
- evt_ready  in  1  consumer accepts the event.
- evt_ch  out  CH_W  index of the offered channel; stable while evt_valid=1.
- overflow  out  N_CH  sticky per-channel overflow flags.
- ovf_clr  in  N_CH  per-channel write-1 clear of overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): prev=0, all cnt=0, overflow=0, state=IDLE, evt_valid=0, evt_ch=0, last=N_CH-1 (so channel 0 has first priority).
- Edge detect per channel i: edge_i = in[i] & ~prev[i] & ch_en[i]; prev[i] <= in[i] every cycle. Because prev resets to 0, an input already high after reset produces one edge.
- take_i = evt_valid & evt_ready & (evt_ch==i).
- Counter update, in priority order:
  - ch_en[i]=0: cnt <= 0.
  - edge & take: cnt unchanged.
  - edge & cnt==MAX: cnt stays MAX, overflow[i] <= 1.
  - edge: cnt+1.
  - take & cnt>0: cnt-1.
  - take & cnt==0: no change (no underflow).
- Overflow clear: ovf_clr[i]=1 clears overflow[i]. If a set event occurs in the same cycle, set wins.
- FSM state IDLE:
  - evt_valid=0.
  - If any cnt>0 (with ch_en), choose the first such channel searching last+1, last+2, … modulo N_CH.
  - Register it into evt_ch and go to OFFER.
- FSM state OFFER:
  - evt_valid=1; evt_ch is held stable.
  - On evt_ready=1: handshake, last <= evt_ch, go to IDLE.
  - Otherwise stay in OFFER. No retraction, even if the channel is disabled meanwhile.
- Latency: edge sampled at posedge k gives cnt=1 after k and evt_valid=1 after posedge k+1 (2 cycles, when IDLE and uncontended).
- Throughput: at most one event per 2 cycles (mandatory IDLE bubble).
- evt_ready while evt_valid=0 is ignored.
- Counts are independent of arbitration: events arriving during OFFER accumulate.

Optional Feature:
- Macro: EDGE_ARB_BOTH_EDGES_EN.
- Defined: edge_i = (in[i] ^ prev[i]) & ch_en[i], so both rising and falling transitions each count one event.
- Undefined: rising edges only, as described above.
- Ports, counters and arbitration are identical in both builds.

Test Plan:
- Reset, then in=4'b0001 held: evt_valid=1 with evt_ch=0 two cycles after the first posedge; ready=1 gives a handshake, then cnt0=0 and no further events while in stays high.
- Pulse ch0, ch1, ch3 in the same cycle with ready=1 constant: grants go 0, 1, 3, each with evt_valid high for 1 cycle separated by 1 idle cycle.
- Hold ready=0 with evt_ch=2 offered while ch0 pulses: evt_ch stays 2 until ready. After accepting, the next grant is ch3 if pending, else ch0 (round-robin from last=2).
- With CNT_W=4, apply 16 rising edges on ch1 with ready=0: cnt1 saturates at 15 and overflow[1]=1. ovf_clr[1]=1 clears the flag; 15 handshakes drain the count.
- Edge and handshake on the same channel in the same cycle with cnt=3: cnt stays 3. Deassert ch_en during OFFER: the offer holds, ready gives a handshake, no underflow, no further events.
- Assert rst_n=0 mid-OFFER: evt_valid drops immediately (asynchronously), and all counters and overflow flags read 0 after release.
